// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with a valid/ready select handshake
// and an autonomous scan mode that walks one active bit across all outputs.
module onehot_decoder_seq #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    output logic                    sel_ready,
    output logic [(1<<SEL_W)-1:0]   out,
    output logic                    out_valid,
    output logic                    scan_wrap
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [OUT_W-1:0] BIT0     = OUT_W'(1);
    localparam logic [SEL_W-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN
    } state_e;

    state_e             state_q;
    logic [OUT_W-1:0]   out_q;
    logic               out_valid_q;
    logic               scan_wrap_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               transfer;
    logic               dwell_done;
    logic [SEL_W-1:0]   ptr_inc;

    // Ready is combinational so a transfer can land on the very edge that
    // leaves IDLE or SCAN for DIRECT.
    assign sel_ready  = rst_n & enable & ~mode;
    assign transfer   = sel_valid & sel_ready;
    assign dwell_done = (cnt_q == CNT_LAST);
    assign ptr_inc    = ptr_q + SEL_W'(1);

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch below reads the pre-edge values of the _q registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is simply the highest-priority branch.
        if (!rst_n || !enable) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            scan_wrap_q <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else if (!mode) begin
            state_q     <= ST_DIRECT;
            scan_wrap_q <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            if (transfer) begin
                out_q       <= BIT0 << sel;
                out_valid_q <= 1'b1;
            end else if (state_q != ST_DIRECT) begin
                out_q       <= '0;
                out_valid_q <= 1'b0;
            end
        end else begin
            state_q     <= ST_SCAN;
            out_valid_q <= 1'b1;
            if (state_q != ST_SCAN) begin
                // Every scan entry restarts at bit 0 with a fresh dwell.
                ptr_q       <= '0;
                cnt_q       <= '0;
                out_q       <= BIT0;
                scan_wrap_q <= 1'b0;
            end else if (dwell_done) begin
                ptr_q       <= ptr_inc;
                cnt_q       <= '0;
                out_q       <= BIT0 << ptr_inc;
                scan_wrap_q <= (ptr_q == PTR_LAST);
            end else begin
                cnt_q       <= cnt_q + CNT_W'(1);
                scan_wrap_q <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Parametrised, registered binary-to-one-hot decoder with a valid/ready input handshake and an autonomous scan mode. In DIRECT mode it decodes accepted select codes to a held one-hot output. In SCAN mode it walks a single active bit across all outputs with a programmable dwell time, for row/LED/chip-select sequencing. It generalises the team's 2-to-4 enable decoder to SEL_W inputs and 2^SEL_W outputs, with defined disable behaviour and a scan sequencer.

Parameters:
SEL_W, 3, select code width; legal range 1..8; OUT_W = 2^SEL_W (derived localparam).
DWELL, 4, cycles each position is held in SCAN mode; legal range >= 1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous reset, active-low.
enable  in  1  block enable; 0 forces outputs off.
mode  in  1  0 = DIRECT decode, 1 = SCAN sequencing.
sel_valid  in  1  sel is valid this cycle.
sel  in  SEL_W  binary select code.
sel_ready  out  1  combinational: rst_n & enable & ~mode.
out  out  OUT_W  registered one-hot output; all-zero when inactive.
out_valid  out  1  registered; 1 whenever out is one-hot (never with out==0).
scan_wrap  out  1  registered 1-cycle pulse on SCAN wrap-around.

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=IDLE; out=0, out_valid=0, scan_wrap=0.
  - Scan pointer and dwell counter cleared.
  - sel_ready is 0 while rst_n=0.
- Priority at each edge: rst_n, then enable, then mode.
- States: IDLE, DIRECT, SCAN.
  - enable=0 -> IDLE (from any state): out=0, out_valid=0, pointer and counter cleared.
  - enable=1, mode=0 -> DIRECT.
  - enable=1, mode=1 -> SCAN.
- DIRECT handshake:
  - Transfer when sel_valid & sel_ready at an edge.
  - Next cycle: out = 1 << sel, out_valid=1 (latency 1 cycle).
  - out holds until the next transfer, which may be back-to-back every cycle.
  - A transfer on the IDLE->DIRECT edge is accepted.
  - Without a transfer, out holds its last value. On entry from SCAN or IDLE, out=0 and out_valid=0 until the first transfer.
- SCAN:
  - Entry edge: pointer=0, out=1 (bit 0), out_valid=1, counter=0.
  - Each following edge: if counter==DWELL-1, pointer increments and counter clears; otherwise counter increments. Each position is therefore held exactly DWELL cycles.
  - Pointer wraps from OUT_W-1 to 0. scan_wrap=1 for exactly the cycle out returns to bit 0 after a wrap. It is not asserted on initial entry.
  - sel_ready=0; sel and sel_valid are ignored.
  - DWELL=1: the pointer advances every cycle.
- Mode changes while enable=1:
  - SCAN->DIRECT: next cycle out=0, out_valid=0, unless a transfer occurs at that edge, in which case out = 1 << sel.
  - DIRECT->SCAN: restarts at bit 0 as on entry.
- Reset or disable mid-scan: the next SCAN entry always restarts at bit 0, counter 0.
- Width rules:
  - Counter width is clog2(DWELL), minimum 1 bit.
  - out is never multi-hot. out is never X after reset, even if sel has X with sel_valid=0.

Test Plan:
- Reset, then enable=1, mode=0; sel=3'd5 with sel_valid=1 for 1 cycle -> next cycle out=8'b0010_0000, out_valid=1, held while sel_valid=0.
- Back-to-back transfers sel=0,1,7 on 3 consecutive edges -> out=01h, 02h, 80h on consecutive cycles; sel_ready=1 throughout.
- mode=1, DWELL=4 -> out=01h for 4 cycles, 02h for 4 cycles, ... 80h for 4 cycles; then 01h with scan_wrap=1 for that single cycle only (32 cycles after entry).
- enable dropped mid-scan at out=08h -> next cycle out=00h, out_valid=0; re-enable with mode=1 -> out=01h, not 10h.
- rst_n=0 for 1 edge during DIRECT with out=40h and sel_valid=1 -> out=00h, out_valid=0, scan_wrap=0; sel_ready=0 while rst_n=0.
- DWELL=1, SEL_W=1 build: mode=1 -> out alternates 01,10 every cycle; scan_wrap pulses every 2nd cycle. Switching to mode=0 with no transfer -> out=00, out_valid=0.
